// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM states,
// width defaults and the write-protected register addresses.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  localparam logic [15:0] PSW_ADDR   = 16'hFFFB;
  localparam logic [15:0] PORTB_ADDR = 16'hFFFD;
  localparam logic [15:0] PORTD_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    DONE
  } arb_state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Round-robin grant between two requesters; the last winner loses a tie.
// grant is combinational; last_grant advances only when a grant is taken.
module mem_arb_rr (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant
);

  logic last_grant;

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) grant = ~last_grant;
    else if (req1)    grant = 1'b1;
  end

  // Reset to 1 so requester 0 wins the first contention
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      last_grant <= 1'b1;
    else if (update) last_grant <= grant;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: IDLE -> ACCESS -> RESP -> DONE per transaction.
// Optional macro MEM_ARB_WPROT_EN blocks writes to PSW/PORTB/PORTD and flags err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_abus,
  output logic [DATA_W-1:0] mem_wbus,
  input  logic [DATA_W-1:0] mem_rbus,
  output logic              busy
);

  arb_state_t        state, state_nxt;
  logic              grant, start;
  logic              win_q, we_q;
  logic              sel_we, sel_prot;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign start     = (state == IDLE) && (m0_req || m1_req);
  assign sel_we    = grant ? m1_we    : m0_we;
  assign sel_addr  = grant ? m1_addr  : m0_addr;
  assign sel_wdata = grant ? m1_wdata : m0_wdata;

  mem_arb_rr u_rr (
    .clk   (clk),
    .reset (reset),
    .req0  (m0_req),
    .req1  (m1_req),
    .update(start),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is latched at the IDLE exit edge; later req/addr changes are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      mem_we   <= 1'b0;
      mem_abus <= '0;
      mem_wbus <= '0;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      busy   <= (state_nxt != IDLE);
      mem_we <= start && sel_we && !sel_prot;
      m0_ack <= (state == RESP) && !win_q;
      m1_ack <= (state == RESP) && win_q;
      if (start) begin
        win_q    <= grant;
        we_q     <= sel_we;
        mem_abus <= sel_addr;
        mem_wbus <= sel_wdata;
      end
      // mem_rbus is valid in RESP, one cycle after the address was presented
      if ((state == RESP) && !we_q) begin
        if (win_q) m1_rdata <= mem_rbus;
        else       m0_rdata <= mem_rbus;
      end
    end
  end

`ifdef MEM_ARB_WPROT_EN
  logic prot_q;

  assign sel_prot = sel_we && ((sel_addr == ADDR_W'(PSW_ADDR))   ||
                               (sel_addr == ADDR_W'(PORTB_ADDR)) ||
                               (sel_addr == ADDR_W'(PORTD_ADDR)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prot_q <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
    end else begin
      if (start) prot_q <= sel_prot;
      m0_err <= (state == RESP) && prot_q && !win_q;
      m1_err <= (state == RESP) && prot_q && win_q;
    end
  end
`else
  assign sel_prot = 1'b0;
  assign m0_err   = 1'b0;
  assign m1_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// rounds checked against a transaction-level model of arbitration and memory.
module tb_mem_arbiter;

`ifdef MEM_ARB_WPROT_EN
  localparam bit WPROT_ON = 1'b1;
`else
  localparam bit WPROT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        mem_we, busy;
  logic [15:0] mem_abus;
  logic [7:0]  mem_wbus;
  logic [7:0]  mem_rbus = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         last_g;
  logic [7:0] exp_rd [2];
  logic [7:0] ref_mem [0:65535];

  // Memory unit environment (written only by the DUT or the preload port)
  logic [7:0]  mem [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_a = 16'h0;
  logic [7:0]  pre_d = 8'h0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_abus(mem_abus), .mem_wbus(mem_wbus),
    .mem_rbus(mem_rbus), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we)      mem[pre_a] <= pre_d;
    else if (mem_we) mem[mem_abus] <= mem_wbus;
    mem_rbus <= mem[mem_abus];
  end

  function automatic bit prot_addr(input logic [15:0] a);
    return WPROT_ON && (a == 16'hFFFB || a == 16'hFFFD || a == 16'hFFFF);
  endfunction

  task automatic drive_req(input int who, input logic r, input logic we,
                           input logic [15:0] a, input logic [7:0] d);
    if (who == 0) begin m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d; end
    else          begin m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    drive_req(0, 0, 0, 16'h0, 8'h0);
    drive_req(1, 0, 0, 16'h0, 8'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    last_g = 1; exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
  endtask

  // Runs one single-requester transaction and reports what was observed
  task automatic run_one(input int who, input logic we, input logic [15:0] a,
                         input logic [7:0] d, output int lat, output int wec,
                         output logic [15:0] wa, output logic [7:0] wd,
                         output logic [7:0] rd, output logic er, output int oth);
    lat = -1; wec = 0; wa = 16'h0; wd = 8'h0; rd = 8'h0; er = 1'b0; oth = 0;
    @(negedge clk);
    drive_req(who, 1, we, a, d);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_we) begin wec++; wa = mem_abus; wd = mem_wbus; end
      if ((who == 0) ? m1_ack : m0_ack) oth++;
      if ((who == 0) ? m0_ack : m1_ack) begin
        lat = k;
        rd  = (who == 0) ? m0_rdata : m1_rdata;
        er  = (who == 0) ? m0_err : m1_err;
        drive_req(who, 0, 0, 16'h0, 8'h0);
        break;
      end
    end
    if (lat < 0) drive_req(who, 0, 0, 16'h0, 8'h0);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_abus !== 16'h0) begin n_bad++; $display("FAIL reset_abus: got %h want 0000", mem_abus); end
    n_cmp++; if (mem_wbus !== 8'h0) begin n_bad++; $display("FAIL reset_wbus: got %h want 00", mem_wbus); end
    n_cmp++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0) begin n_bad++; $display("FAIL reset_ack_err: got %b want 0000", {m0_ack, m1_ack, m0_err, m1_err}); end
    n_cmp++; if ({m0_rdata, m1_rdata} !== 16'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0000", {m0_rdata, m1_rdata}); end
    reset = 1'b1;
    last_g = 1; exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, m0_ack, m1_ack} !== 3'b0) begin n_bad++; $display("FAIL reset_release_idle: got %b want 000", {busy, m0_ack, m1_ack}); end
  endtask

  task automatic test_write;
    int lat, wec, oth; logic [15:0] wa; logic [7:0] wd, rd; logic er;
    run_one(0, 1'b1, 16'h0200, 8'hA5, lat, wec, wa, wd, rd, er, oth);
    last_g = 0;
    ref_mem[16'h0200] = 8'hA5;
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
    n_cmp++; if (wec != 1) begin n_bad++; $display("FAIL wr_we_cycles: got %0d want 1", wec); end
    n_cmp++; if (wa !== 16'h0200) begin n_bad++; $display("FAIL wr_abus: got %h want 0200", wa); end
    n_cmp++; if (wd !== 8'hA5) begin n_bad++; $display("FAIL wr_wbus: got %h want a5", wd); end
    n_cmp++; if (er !== 1'b0 || oth != 0) begin n_bad++; $display("FAIL wr_err_other: got err=%b oth=%0d want 0/0", er, oth); end
    n_cmp++; if (mem[16'h0200] !== ref_mem[16'h0200]) begin n_bad++; $display("FAIL wr_mem: got %h want %h", mem[16'h0200], ref_mem[16'h0200]); end
    n_cmp++; if (m0_rdata !== exp_rd[0]) begin n_bad++; $display("FAIL wr_rdata_kept: got %h want %h", m0_rdata, exp_rd[0]); end
  endtask

  task automatic test_read;
    int lat, wec, oth; logic [15:0] wa; logic [7:0] wd, rd; logic er;
    preload(16'h0200, 8'hA5);
    run_one(1, 1'b0, 16'h0200, 8'h00, lat, wec, wa, wd, rd, er, oth);
    last_g = 1;
    exp_rd[1] = ref_mem[16'h0200];
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== exp_rd[1]) begin n_bad++; $display("FAIL rd_data_at_ack: got %h want %h", rd, exp_rd[1]); end
    n_cmp++; if (m1_rdata !== exp_rd[1]) begin n_bad++; $display("FAIL rd_data_held: got %h want %h", m1_rdata, exp_rd[1]); end
    n_cmp++; if (m0_rdata !== exp_rd[0]) begin n_bad++; $display("FAIL rd_m0_untouched: got %h want %h", m0_rdata, exp_rd[0]); end
    n_cmp++; if (wec != 0 || er !== 1'b0) begin n_bad++; $display("FAIL rd_no_write: got we=%0d err=%b want 0/0", wec, er); end
  endtask

  task automatic test_wprot;
    int lat, wec, oth; logic [15:0] wa; logic [7:0] wd, rd; logic er; bit p;
    preload(16'hFFFB, 8'h12);
    run_one(0, 1'b1, 16'hFFFB, 8'hFF, lat, wec, wa, wd, rd, er, oth);
    last_g = 0;
    p = prot_addr(16'hFFFB);
    if (!p) ref_mem[16'hFFFB] = 8'hFF;
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL wprot_latency: got %0d want 3", lat); end
    n_cmp++; if (wec != (p ? 0 : 1)) begin n_bad++; $display("FAIL wprot_we_cycles: got %0d want %0d", wec, p ? 0 : 1); end
    n_cmp++; if (er !== p) begin n_bad++; $display("FAIL wprot_err: got %b want %b", er, p); end
    n_cmp++; if (mem[16'hFFFB] !== ref_mem[16'hFFFB]) begin n_bad++; $display("FAIL wprot_psw: got %h want %h", mem[16'hFFFB], ref_mem[16'hFFFB]); end
  endtask

  task automatic test_rr;
    logic [15:0] a0, a1; int n, w, who;
    apply_reset;
    a0 = 16'h0401; a1 = 16'h0402; n = 0;
    @(negedge clk);
    drive_req(0, 1, 0, a0, 8'h00);
    drive_req(1, 1, 0, a1, 8'h00);
    for (int cyc = 1; cyc <= 30 && n < 4; cyc++) begin
      @(negedge clk);
      n_cmp++; if (busy !== ((cyc % 4) != 0)) begin n_bad++; $display("FAIL rr_busy c%0d: got %b want %b", cyc, busy, (cyc % 4) != 0); end
      if (m0_ack || m1_ack) begin
        who = m1_ack ? 1 : 0;
        w = 1 - last_g; last_g = w;
        exp_rd[w] = ref_mem[(w == 1) ? a1 : a0];
        n_cmp++; if ((m0_ack && m1_ack) || who != w) begin n_bad++; $display("FAIL rr_order #%0d: got acks %b%b want m%0d", n, m0_ack, m1_ack, w); end
        n_cmp++; if (cyc != 3 + 4 * n) begin n_bad++; $display("FAIL rr_timing #%0d: got cycle %0d want %0d", n, cyc, 3 + 4 * n); end
        n_cmp++; if ({m0_rdata, m1_rdata} !== {exp_rd[0], exp_rd[1]}) begin n_bad++; $display("FAIL rr_rdata #%0d: got %h want %h", n, {m0_rdata, m1_rdata}, {exp_rd[0], exp_rd[1]}); end
        n++;
        if (n == 4) begin drive_req(0, 0, 0, 16'h0, 8'h0); drive_req(1, 0, 0, 16'h0, 8'h0); end
      end
    end
    n_cmp++; if (n != 4) begin n_bad++; $display("FAIL rr_timeout: got %0d acks want 4", n); drive_req(0, 0, 0, 16'h0, 8'h0); drive_req(1, 0, 0, 16'h0, 8'h0); end
  endtask

  task automatic test_random;
    int r, n, w, who, wec, exp_wec, sel;
    int order[$];
    logic we_r [2]; logic [15:0] a_r [2]; logic [7:0] d_r [2];
    logic exp_err;
    logic [15:0] prot_tbl [3];
    prot_tbl[0] = 16'hFFFB; prot_tbl[1] = 16'hFFFD; prot_tbl[2] = 16'hFFFF;
    apply_reset;
    for (int rnd = 0; rnd < 25; rnd++) begin
      r = $urandom_range(1, 3);
      for (int i = 0; i < 2; i++) begin
        we_r[i] = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 9);
        a_r[i] = (sel == 0) ? prot_tbl[$urandom_range(0, 2)] : 16'h0400 + 16'($urandom_range(0, 7));
        d_r[i] = 8'($urandom);
      end
      order.delete();
      if (r == 3) begin w = 1 - last_g; order.push_back(w); order.push_back(1 - w); end
      else order.push_back((r == 1) ? 0 : 1);
      exp_wec = 0;
      foreach (order[k]) if (we_r[order[k]] && !prot_addr(a_r[order[k]])) exp_wec++;
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (r[i]) drive_req(i, 1, we_r[i], a_r[i], d_r[i]);
      n = 0; wec = 0;
      for (int cyc = 1; cyc <= 20 && n < order.size(); cyc++) begin
        @(negedge clk);
        if (mem_we) wec++;
        if (m0_ack || m1_ack) begin
          who = m1_ack ? 1 : 0;
          w = order[n]; last_g = w;
          exp_err = we_r[w] && prot_addr(a_r[w]);
          if (we_r[w]) begin if (!exp_err) ref_mem[a_r[w]] = d_r[w]; end
          else exp_rd[w] = ref_mem[a_r[w]];
          n_cmp++; if ((m0_ack && m1_ack) || who != w) begin n_bad++; $display("FAIL rnd%0d_who #%0d: got acks %b%b want m%0d", rnd, n, m0_ack, m1_ack, w); end
          n_cmp++; if (cyc != 3 + 4 * n) begin n_bad++; $display("FAIL rnd%0d_timing #%0d: got cycle %0d want %0d", rnd, n, cyc, 3 + 4 * n); end
          n_cmp++; if ({m0_rdata, m1_rdata} !== {exp_rd[0], exp_rd[1]}) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h want %h", rnd, {m0_rdata, m1_rdata}, {exp_rd[0], exp_rd[1]}); end
          n_cmp++; if ({m0_err, m1_err} !== {(w == 0) && exp_err, (w == 1) && exp_err}) begin n_bad++; $display("FAIL rnd%0d_err: got %b%b want %b%b", rnd, m0_err, m1_err, (w == 0) && exp_err, (w == 1) && exp_err); end
          drive_req(who, 0, 0, 16'h0, 8'h0);
          n++;
        end
      end
      n_cmp++; if (n != order.size()) begin n_bad++; $display("FAIL rnd%0d_timeout: got %0d acks want %0d", rnd, n, order.size()); drive_req(0, 0, 0, 16'h0, 8'h0); drive_req(1, 0, 0, 16'h0, 8'h0); end
      n_cmp++; if (wec != exp_wec) begin n_bad++; $display("FAIL rnd%0d_we_cycles: got %0d want %0d", rnd, wec, exp_wec); end
      for (int i = 0; i < 2; i++) if (r[i] && we_r[i]) begin
        n_cmp++; if (mem[a_r[i]] !== ref_mem[a_r[i]]) begin n_bad++; $display("FAIL rnd%0d_mem %h: got %h want %h", rnd, a_r[i], mem[a_r[i]], ref_mem[a_r[i]]); end
      end
    end
  endtask

  task automatic test_reset_abort;
    int acks, lat, wec, oth; logic [15:0] wa; logic [7:0] wd, rd; logic er;
    acks = 0;
    @(negedge clk);
    drive_req(0, 1, 1, 16'h0300, 8'h5A);
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL abort_access_we: got %b want 1", mem_we); end
    #2 reset = 1'b0;
    drive_req(0, 0, 0, 16'h0, 8'h0);
    #1;
    n_cmp++; if ({mem_we, busy} !== 2'b00) begin n_bad++; $display("FAIL abort_async_drop: got we/busy %b want 00", {mem_we, busy}); end
    repeat (3) begin @(negedge clk); if (m0_ack || m1_ack) acks++; end
    reset = 1'b1;
    last_g = 1; exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    repeat (4) begin @(negedge clk); if (m0_ack || m1_ack) acks++; end
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
    n_cmp++; if (mem[16'h0300] !== ref_mem[16'h0300]) begin n_bad++; $display("FAIL abort_mem: got %h want %h", mem[16'h0300], ref_mem[16'h0300]); end
    run_one(0, 1'b0, 16'h0300, 8'h00, lat, wec, wa, wd, rd, er, oth);
    last_g = 0;
    exp_rd[0] = ref_mem[16'h0300];
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL abort_read_latency: got %0d want 3", lat); end
    n_cmp++; if (m0_rdata !== exp_rd[0]) begin n_bad++; $display("FAIL abort_read_data: got %h want %h", m0_rdata, exp_rd[0]); end
  endtask

  initial begin
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 16'h0; m0_wdata = 8'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'h0; m1_wdata = 8'h0;
    test_reset;
    for (int i = 0; i < 8; i++) preload(16'h0400 + 16'(i), 8'($urandom));
    preload(16'hFFFD, 8'($urandom));
    preload(16'hFFFF, 8'($urandom));
    preload(16'h0300, 8'($urandom));
    test_write;
    test_read;
    test_wprot;
    test_rr;
    test_random;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
